// File: rtl/sync_fifo_pkg.sv
// Shared constants, types and helpers for the programmable synchronous FIFO.
package sync_fifo_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    // The occupancy counter needs one extra bit so it can hold DEPTH itself.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almostfull;
        logic almostempty;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage array: one synchronous write port, one asynchronous read address.
module sync_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset; occupancy tracking makes stale words invisible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and error tracking.
// Define SYNC_FIFO_FWFT_EN to build the first-word-fall-through read variant.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              data_out,
    output logic                          rd_valid,
    output logic                          wr_ack,
    output logic                          full,
    output logic                          empty,
    output logic                          almostfull,
    output logic                          almostempty,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          ovf_sticky,
    output logic                          udf_sticky,
    input  logic                          err_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             wr_ack_q, wr_ack_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             udf_sticky_q, udf_sticky_d;
    logic             wr_accept, rd_accept;
    logic [WIDTH-1:0] mem_rd_data;
    fifo_status_t     status;

    assign status.full        = (level_q == LW'(DEPTH));
    assign status.empty       = (level_q == '0);
    assign status.almostfull  = (level_q >= LW'(AF_LEVEL));
    assign status.almostempty = (level_q <= LW'(AE_LEVEL));

    assign wr_accept = wr_en && !status.full && !flush;
    assign rd_accept = rd_en && !status.empty && !flush;

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

    // Flush wins over both requests; error pulses are raised even when the other side proceeds.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        wr_ack_d     = 1'b0;
        overflow_d   = wr_en && status.full && !flush;
        underflow_d  = rd_en && status.empty && !flush;
        ovf_sticky_d = overflow_d || (ovf_sticky_q && !err_clr);
        udf_sticky_d = underflow_d || (udf_sticky_q && !err_clr);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                wr_ack_d = 1'b1;
            end
            if (rd_accept) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            wr_ack_q     <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            ovf_sticky_q <= 1'b0;
            udf_sticky_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            wr_ack_q     <= wr_ack_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            ovf_sticky_q <= ovf_sticky_d;
            udf_sticky_q <= udf_sticky_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is shown directly; gating on empty keeps data_out at zero through reset.
    assign data_out = status.empty ? '0 : mem_rd_data;
    assign rd_valid = !status.empty;
`else
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             rd_valid_q, rd_valid_d;

    always_comb begin
        data_out_d = rd_accept ? mem_rd_data : data_out_q;
        rd_valid_d = rd_accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
`endif

    assign wr_ack      = wr_ack_q;
    assign full        = status.full;
    assign empty       = status.empty;
    assign almostfull  = status.almostfull;
    assign almostempty = status.almostempty;
    assign level       = level_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign ovf_sticky  = ovf_sticky_q;
    assign udf_sticky  = udf_sticky_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed self-checking bench for sync_fifo_prog (WIDTH=16, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2).
module tb_sync_fifo_prog;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        wr_en;
    logic [15:0] data_in;
    logic        rd_en;
    logic [15:0] data_out;
    logic        rd_valid;
    logic        wr_ack;
    logic        full;
    logic        empty;
    logic        almostfull;
    logic        almostempty;
    logic [3:0]  level;
    logic        overflow;
    logic        underflow;
    logic        ovf_sticky;
    logic        udf_sticky;
    logic        err_clr;

    int checkCount = 0;
    int passCount  = 0;

    sync_fifo_prog #(
        .WIDTH    (16),
        .DEPTH    (8),
        .AF_LEVEL (6),
        .AE_LEVEL (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .rd_valid    (rd_valid),
        .wr_ack      (wr_ack),
        .full        (full),
        .empty       (empty),
        .almostfull  (almostfull),
        .almostempty (almostempty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow),
        .ovf_sticky  (ovf_sticky),
        .udf_sticky  (udf_sticky),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic w, input logic [15:0] d, input logic r,
                                 input logic f, input logic c);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        flush   = f;
        err_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_level"},    32'(level), 32'd0);
        checkOutput({tag, "_flags"},    32'({full, empty, almostfull, almostempty}), 32'b0101);
        checkOutput({tag, "_data_out"}, 32'(data_out), 32'd0);
        checkOutput({tag, "_strobes"},  32'({rd_valid, wr_ack, overflow, underflow}), 32'd0);
        checkOutput({tag, "_stickies"}, 32'({ovf_sticky, udf_sticky}), 32'd0);
    endtask

    int          modelQ[$];
    logic        mFull, mEmpty, wAcc, rAcc, wReq, rReq;
    logic [15:0] expData;

    initial begin
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0; err_clr = 1'b0;
        #2;
        checkReset("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill with 1..8, then drain in order.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
            checkOutput("fill_level", 32'(level), 32'(i));
            checkOutput("fill_wr_ack", 32'(wr_ack), 32'd1);
            checkOutput("fill_af", 32'(almostfull), 32'(i >= 6));
            checkOutput("fill_ae", 32'(almostempty), 32'(i <= 2));
        end
        checkOutput("fill_full", 32'(full), 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_wr_ack", 32'(wr_ack), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
            checkOutput("drain_data", 32'(data_out), 32'(i));
            checkOutput("drain_valid", 32'(rd_valid), 32'd1);
            checkOutput("drain_level", 32'(level), 32'(8 - i));
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_valid", 32'(rd_valid), 32'd0);
        checkOutput("hold_data", 32'(data_out), 32'h8);

        // Overflow at full with simultaneous read.
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 16'(16'h10 + i), 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_full", 32'(full), 32'd1);
        applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        checkOutput("ovf_level", 32'(level), 32'd7);
        checkOutput("ovf_pulse", 32'(overflow), 32'd1);
        checkOutput("ovf_sticky", 32'(ovf_sticky), 32'd1);
        checkOutput("ovf_wr_ack", 32'(wr_ack), 32'd0);
        checkOutput("ovf_data", 32'(data_out), 32'h11);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_pulse_end", 32'(overflow), 32'd0);
        checkOutput("ovf_sticky_hold", 32'(ovf_sticky), 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_sticky_clr", 32'(ovf_sticky), 32'd0);
        for (int i = 2; i <= 8; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
            checkOutput("ovf_drain_data", 32'(data_out), 32'(16'h10 + i));
        end
        checkOutput("ovf_drain_empty", 32'(empty), 32'd1);

        // Underflow, sticky set-wins-over-clear, and write+read at empty.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
            checkOutput("udf_pulse", 32'(underflow), 32'd1);
            checkOutput("udf_level", 32'(level), 32'd0);
            checkOutput("udf_sticky", 32'(udf_sticky), 32'd1);
            checkOutput("udf_valid", 32'(rd_valid), 32'd0);
        end
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("udf_set_wins", 32'(udf_sticky), 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("udf_sticky_clr", 32'(udf_sticky), 32'd0);
        checkOutput("udf_pulse_end", 32'(underflow), 32'd0);
        applyStimulus(1'b1, 16'h0055, 1'b1, 1'b0, 1'b0);
        checkOutput("empty_wr_rd_level", 32'(level), 32'd1);
        checkOutput("empty_wr_rd_udf", 32'(underflow), 32'd1);
        checkOutput("empty_wr_rd_ack", 32'(wr_ack), 32'd1);
        checkOutput("empty_wr_rd_valid", 32'(rd_valid), 32'd0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("empty_wr_rd_data", 32'(data_out), 32'h55);
        checkOutput("empty_wr_rd_drain", 32'(level), 32'd0);

        // Flush dominates a concurrent write and keeps data_out.
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 16'(16'h20 + i), 1'b0, 1'b0, 1'b0);
        checkOutput("flush_pre_level", 32'(level), 32'd5);
        applyStimulus(1'b1, 16'h0099, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_level", 32'(level), 32'd0);
        checkOutput("flush_empty", 32'(empty), 32'd1);
        checkOutput("flush_wr_ack", 32'(wr_ack), 32'd0);
        checkOutput("flush_data", 32'(data_out), 32'h55);
        applyStimulus(1'b1, 16'h0077, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("post_flush_data", 32'(data_out), 32'h77);

        // Interleaved burst against a queue model; pointers wrap several times.
        for (int i = 0; i < 32; i++) begin
            wReq   = (i % 4) != 3;
            rReq   = (i % 2) == 1;
            mFull  = modelQ.size() == 8;
            mEmpty = modelQ.size() == 0;
            wAcc   = wReq && !mFull;
            rAcc   = rReq && !mEmpty;
            if (rAcc) expData = 16'(modelQ.pop_front());
            if (wAcc) modelQ.push_back(16'h100 + i);
            applyStimulus(wReq, 16'(16'h100 + i), rReq, 1'b0, 1'b0);
            checkOutput("burst_level", 32'(level), 32'(modelQ.size()));
            checkOutput("burst_af", 32'(almostfull), 32'(modelQ.size() >= 6));
            checkOutput("burst_ae", 32'(almostempty), 32'(modelQ.size() <= 2));
            checkOutput("burst_wr_ack", 32'(wr_ack), 32'(wAcc));
            checkOutput("burst_valid", 32'(rd_valid), 32'(rAcc));
            checkOutput("burst_ovf", 32'(overflow), 32'(wReq && mFull));
            if (rAcc) checkOutput("burst_data", 32'(data_out), 32'(expData));
        end

        // Asynchronous reset in the middle of a burst.
        wr_en = 1'b1; data_in = 16'h0DAD; rd_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkReset("midrst");
        @(posedge clk);
        #1;
        checkReset("midrst_held");
        rst = 1'b0;
        applyStimulus(1'b1, 16'h00A5, 1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_level", 32'(level), 32'd1);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("post_rst_data", 32'(data_out), 32'hA5);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
